instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's immediate extender: packs opcode, funct, register and 32-bit immediate fields into a 32-bit RV32I instruction word.
- Writes encoded words sequentially into instruction memory through a 2-entry FIFO.
- Sits between the bench/boot loader and the imem write port; used to load programs and to round-trip check immediate extension.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- FIFO_DEPTH, 2, entries between the encode stage and the memory write port (power of 2, ≥2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a program load; ignored unless in IDLE
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_last  input  1  marks the final request of the program
- in_fmt  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110 and 111 are illegal
- in_opcode  input  7  opcode field
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field (R only)
- in_rd, in_rs1, in_rs2  input  5 each  register fields
- in_imm  input  32  byte-offset immediate, full value
- mem_we  output  1  write request
- mem_ready  input  1  memory accepts the write this cycle
- mem_addr  output  32  word byte address
- mem_wdata  output  32  encoded instruction
- err_pulse  output  1  one-cycle pulse: the accepted request was rejected
- err_code  output  2  00 none, 01 illegal fmt, 10 imm out of range, 11 misaligned imm; held until the next error or start
- done  output  1  one-cycle pulse when the load completes
- count  output  16  words written since start

Behaviour:
- Reset: FSM IDLE; FIFO empty; mem_addr=BASE_ADDR; count=0; all other outputs 0.
- FSM: IDLE -> RUN on start. RUN -> DRAIN on accepting a request with in_last=1, whether or not it errors. DRAIN -> IDLE when FIFO is empty and no write is outstanding; done pulses on that transition.
- in_ready = (state==RUN) && FIFO not full.
- Encoding is combinational at acceptance; the word is pushed into the FIFO the same cycle. Latency: accept in cycle N -> mem_we earliest in N+1.
- Field packing:
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - U: imm[31:12], rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
- Range checks (error = nothing pushed, err_pulse=1, err_code set):
  - I/S: in_imm[31:11] all equal, else code 10.
  - B: in_imm[31:12] all equal, else 10; in_imm[0]=0, else 11.
  - J: in_imm[31:20] all equal, else 10; in_imm[0]=0, else 11.
  - U: in_imm[11:0]=0, else 11.
  - fmt 110/111: code 01.
  - If both range and alignment fail, code 10 takes priority.
- Memory port: mem_we = FIFO not empty; mem_wdata = FIFO head.
  - mem_we && mem_ready: pop, mem_addr += 4 (wraps modulo 2^32), count += 1 (saturates at 16'hFFFF).
  - mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
- Simultaneous push and pop with the FIFO full is allowed only if the pop is known this cycle. in_ready is not combinationally dependent on mem_ready, so a full FIFO deasserts in_ready.
- start in IDLE: mem_addr=BASE_ADDR, count=0, err_code=00. start in RUN or DRAIN is ignored.
- Asynchronous reset mid-load: FIFO is flushed, the partial program is abandoned, and no done pulse is issued.

Decomposition:
- Shared package rv_pkg:
  - imm_fmt_t enum (I,S,B,J,U,R), with encoding 0–3 identical to the extender's immsrc.
  - err_code_t.
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_OP, OP_IMM).
- Sub-module sync_fifo (parameterised WIDTH, DEPTH; full/empty flags).
- The encode/check logic stays in a function inside instr_encoder.

Test Plan:
- I-type addi x5,x0,-1 (opcode 0010011, imm=32'hFFFF_FFFF), mem_ready=1 -> mem_wdata=32'hFFF0_0293 at mem_addr=0, count=1.
- B-type beq x1,x2,-4 -> 32'hFE20_8EE3. Round-trip: feed the word to extend with immsrc=10 -> immext=32'hFFFF_FFFC.
- Alignment and range errors -> err_pulse with code 11, no write, count unchanged:
  - J with imm=32'h0000_0003;
  - U with imm=32'h0000_1001.
  - I with imm=32'h0000_0800 -> err_pulse with code 10, no write.
- Backpressure: 4 back-to-back requests with mem_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts;
  - mem_addr/mem_wdata stable while stalled;
  - writes land at 0,4,8,C in order.
- in_last on the 3rd request -> FSM DRAIN, in_ready=0, done pulses exactly once after the 3rd write, then start restarts at BASE_ADDR with count=0.
- Assert reset_n low with 2 FIFO entries pending -> mem_we=0 and state IDLE immediately; no done pulse after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: immediate formats, encoder error codes, opcodes
// and the request/response records used by the instruction encoder.
package rv_pkg;

    // Encodings 0-3 match the immediate extender's immsrc select.
    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4,
        FMT_R = 3'd5
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_FMT   = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_ALIGN = 2'b11
    } err_code_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] word;
        err_code_t   err;
    } enc_rsp_t;

    // True when every bit of the vector is identical (a valid sign run).
    function automatic logic all_same(input logic [31:0] v, input logic [31:0] mask);
        return ((v & mask) == mask) || ((v & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; push is dropped when full and
// pop is dropped when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: empty gates every read of stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words and streams them, in order, to the
// instruction memory write port through a small FIFO.
module instr_encoder
    import rv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic        done,
    output logic [15:0] count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // Range is checked before alignment so a word failing both reports range.
    function automatic enc_rsp_t encode(input enc_req_t r);
        enc_rsp_t o;
        o.word = '0;
        o.err  = ERR_NONE;
        case (r.fmt)
            FMT_I: begin
                o.word = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
                if (!all_same(r.imm, 32'hFFFF_F800)) o.err = ERR_RANGE;
            end
            FMT_S: begin
                o.word = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
                if (!all_same(r.imm, 32'hFFFF_F800)) o.err = ERR_RANGE;
            end
            FMT_B: begin
                o.word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                          r.imm[4:1], r.imm[11], r.opcode};
                if (!all_same(r.imm, 32'hFFFF_F000)) o.err = ERR_RANGE;
                else if (r.imm[0])                   o.err = ERR_ALIGN;
            end
            FMT_J: begin
                o.word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
                if (!all_same(r.imm, 32'hFFF0_0000)) o.err = ERR_RANGE;
                else if (r.imm[0])                   o.err = ERR_ALIGN;
            end
            FMT_U: begin
                o.word = {r.imm[31:12], r.rd, r.opcode};
                if (r.imm[11:0] != 12'h0) o.err = ERR_ALIGN;
            end
            FMT_R: begin
                o.word = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            end
            default: o.err = ERR_FMT;
        endcase
        return o;
    endfunction

    state_t      state;
    err_code_t   err_q;
    enc_req_t    req;
    enc_rsp_t    rsp;
    logic [31:0] head;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;

    assign req = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    assign rsp = encode(req);

    // in_ready depends only on registered state, never on mem_ready.
    assign in_ready  = (state == S_RUN) && !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && (rsp.err == ERR_NONE);
    assign mem_we    = !empty;
    assign pop       = mem_we && mem_ready;
    assign mem_wdata = empty ? 32'h0 : head;
    assign err_code  = err_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (rsp.word),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mem_addr  <= BASE_ADDR;
            count     <= 16'h0;
            err_pulse <= 1'b0;
            err_q     <= ERR_NONE;
            done      <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            done      <= 1'b0;
            if (pop) begin
                mem_addr <= mem_addr + 32'd4;
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        mem_addr <= BASE_ADDR;
                        count    <= 16'h0;
                        err_q    <= ERR_NONE;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (rsp.err != ERR_NONE) begin
                            err_pulse <= 1'b1;
                            err_q     <= rsp.err;
                        end
                        if (in_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // mem_we mirrors !empty, so empty means nothing is outstanding.
                    if (empty) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a cycle-level reference model of the
// load sequence and arithmetic field packing.
module tb_instr_encoder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_ready = 1'b0;
    logic        in_ready, mem_we, err_pulse, done;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [15:0] count;

    instr_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_pulse(err_pulse),
        .err_code(err_code), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference packing built from shifts and masks of the architectural fields.
    function automatic bit [31:0] m_encode(bit [31:0] f, bit [31:0] op, bit [31:0] f3,
                                           bit [31:0] f7, bit [31:0] rd, bit [31:0] rs1,
                                           bit [31:0] rs2, bit [31:0] imm);
        bit [31:0] w;
        w = op;
        case (f)
            0: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
            1: w |= ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((imm >> 5) & 32'h7F) << 25);
            2: w |= (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | (f3 << 12)
                  | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 12) & 1) << 31);
            3: w |= (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
            4: w |= (rd << 7) | (imm & 32'hFFFF_F000);
            default: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
        endcase
        return w;
    endfunction

    // Legality as signed ranges of the byte offset.
    function automatic bit [1:0] m_check(bit [2:0] f, bit [31:0] imm);
        int s;
        s = $signed(imm);
        case (f)
            0, 1: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
            2: begin
                if (s < -4096 || s > 4095) return 2'd2;
                return imm[0] ? 2'd3 : 2'd0;
            end
            3: begin
                if (s < -(1 << 20) || s > (1 << 20) - 1) return 2'd2;
                return imm[0] ? 2'd3 : 2'd0;
            end
            4: return (imm[11:0] != 12'h0) ? 2'd3 : 2'd0;
            5: return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    // B-type immediate extension as the core performs it.
    function automatic bit [31:0] ext_b(bit [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    int          m_state = 0;
    bit [31:0]   m_addr = BASE;
    bit [15:0]   m_count = 0;
    bit [1:0]    m_code = 0;
    bit          p_done = 0, p_err = 0;
    bit [31:0]   q[$];

    always @(negedge clk) begin : monitor
        int sz0;
        bit rdy;
        if (done) done_cnt++;
        if (!reset_n) begin
            q.delete();
            m_state = 0; m_addr = BASE; m_count = 0; m_code = 0;
            p_done = 0; p_err = 0;
            chk("rst_mem_we", mem_we, 1'b0);
        end else begin
            sz0 = q.size();
            rdy = (m_state == 1) && (sz0 < DEPTH);
            chk("in_ready", in_ready, rdy);
            chk("mem_we", mem_we, sz0 != 0);
            if (sz0 != 0 && mem_we) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, q[0]);
            end
            chk("count", count, m_count);
            chk("done", done, p_done);
            chk("err_pulse", err_pulse, p_err);
            chk("err_code", err_code, m_code);
            p_done = 0; p_err = 0;
            if (sz0 != 0 && mem_ready) begin
                void'(q.pop_front());
                m_addr += 4;
                if (m_count != 16'hFFFF) m_count++;
            end
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_addr = BASE; m_count = 0; m_code = 0;
                end
                1: if (in_valid && rdy) begin
                    bit [1:0] c;
                    c = m_check(in_fmt, in_imm);
                    if (c != 0) begin p_err = 1; m_code = c; end
                    else q.push_back(m_encode(in_fmt, in_opcode, in_funct3, in_funct7,
                                              in_rd, in_rs1, in_rs2, in_imm));
                    if (in_last) m_state = 2;
                end
                default: if (sz0 == 0) begin m_state = 0; p_done = 1; end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        int t;
        in_valid = 1; in_last = last; in_fmt = f; in_opcode = op; in_funct3 = f3;
        in_funct7 = f7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (t = 0; t < 30; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
        tick();
    endtask

    task automatic err_now(input string name, input logic [1:0] code, input logic [15:0] cnt);
        @(negedge clk);
        chk({name, "_pulse"}, err_pulse, 1'b1);
        chk({name, "_code"}, err_code, code);
        chk({name, "_nowrite"}, mem_we, 1'b0);
        chk({name, "_count"}, count, cnt);
        tick();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin : stim
        int d0;
        chk("model_addi", m_encode(0, 7'h13, 0, 0, 5, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_0293);
        chk("model_beq", m_encode(2, 7'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC), 32'hFE20_8EE3);
        chk("model_jchk", m_check(3, 32'h3), 2'd3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_count", count, 16'h0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_err", {err_pulse, err_code, done}, 4'h0);
        tick();
        reset_n = 1;
        tick();

        // Load 1: encodings, errors, boundaries
        mem_ready = 1;
        pulse_start();
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("addi_we", mem_we, 1'b1);
        chk("addi_word", mem_wdata, 32'hFFF0_0293);
        chk("addi_addr", mem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("addi_count", count, 16'd1);
        tick();
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 0);
        @(negedge clk);
        chk("beq_word", mem_wdata, 32'hFE20_8EE3);
        chk("beq_addr", mem_addr, 32'h4);
        chk("beq_roundtrip", ext_b(mem_wdata), 32'hFFFF_FFFC);
        tick();
        send(3'd3, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0003, 0);
        err_now("j_align", 2'b11, 16'd2);
        send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001, 0);
        err_now("u_align", 2'b11, 16'd2);
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 0);
        err_now("i_range", 2'b10, 16'd2);
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h0000_1001, 0);
        err_now("b_both", 2'b10, 16'd2);
        send(3'd6, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0, 0);
        err_now("fmt_bad", 2'b01, 16'd2);
        send(3'd1, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFF_F800, 0);
        send(3'd3, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000, 0);
        send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 0);
        send(3'd5, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0, 1);
        wait_done();
        @(negedge clk);
        chk("l1_count", count, 16'd6);
        chk("l1_code_held", err_code, 2'b01);
        tick();

        // Load 2: backpressure
        mem_ready = 0;
        pulse_start();
        @(negedge clk);
        chk("restart_code", err_code, 2'b00);
        chk("restart_addr", mem_addr, BASE);
        tick();
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 0);
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 0);
        @(negedge clk);
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_head", mem_wdata, 32'h0010_0093);
        tick();
        fork
            begin
                send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 0);
                send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4, 1);
            end
            begin
                @(negedge clk);
                chk("bp_stall_addr", mem_addr, 32'h0);
                chk("bp_stall_data", mem_wdata, 32'h0010_0093);
                tick(); start = 1;
                tick(); start = 0;
                tick(); mem_ready = 1;
            end
        join
        wait_done();
        @(negedge clk);
        chk("bp_final_addr", mem_addr, 32'h10);
        chk("bp_final_count", count, 16'd4);
        tick();

        // Load 3: last on third request, single done
        pulse_start();
        send(3'd5, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 0);
        send(3'd1, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd4, 5'd5, 32'd2047, 0);
        send(3'd2, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd6, 5'd7, 32'd4094, 1);
        d0 = done_cnt;
        @(negedge clk);
        chk("drain_ready", in_ready, 1'b0);
        tick();
        wait_done();
        repeat (4) tick();
        chk("done_once", done_cnt - d0, 1);
        chk("l3_count", count, 16'd3);
        pulse_start();
        @(negedge clk);
        chk("l4_addr", mem_addr, BASE);
        chk("l4_count", count, 16'd0);
        tick();

        // Load 4: reset with two entries pending
        mem_ready = 0;
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd6, 0);
        #2 reset_n = 0;
        #1;
        chk("arst_we", mem_we, 1'b0);
        chk("arst_ready", in_ready, 1'b0);
        chk("arst_addr", mem_addr, BASE);
        d0 = done_cnt;
        tick();
        reset_n = 1;
        repeat (6) tick();
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_idle_we", mem_we, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
